// File: rtl/adder_bist.sv
// Built-in self-test engine for the 7-bit adder: LFSR operand generator, latency-aligned
// golden sum pipeline and mismatch accounting with pass/fail summary.
module adder_bist #(
    parameter int unsigned LAT    = 1,
    parameter int unsigned N_PAT  = 256,
    parameter logic [6:0]  SEED_A = 7'h01,
    parameter logic [6:0]  SEED_B = 7'h7F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [6:0]  in_a,
    output logic [6:0]  in_b,
    input  logic [7:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_idx
);

    typedef enum logic [1:0] {StIdle, StGen, StDrain, StDone} state_e;

    localparam logic [15:0] LastIdx   = 16'(N_PAT - 1);
    localparam logic [2:0]  LastDrain = 3'(LAT - 1);

    state_e      state_q, state_d;
    logic [6:0]  lfsr_a_q, lfsr_b_q;
    logic [15:0] idx_q;
    logic [2:0]  drain_q;
    logic [15:0] err_q, first_q;
    logic [7:0]  exp_q  [LAT];
    logic        vld_q  [LAT];
    logic [15:0] pidx_q [LAT];

    logic       load, last_pair, mismatch;
    logic [7:0] sum;

    assign load      = start && (state_q == StIdle || state_q == StDone);
    assign last_pair = (idx_q == LastIdx);
    assign sum       = {1'b0, lfsr_a_q} + {1'b0, lfsr_b_q};
    assign mismatch  = vld_q[LAT-1] && (dut_out != exp_q[LAT-1]);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StGen;
            StGen:   if (last_pair) state_d = StDrain;
            StDrain: if (drain_q == LastDrain) state_d = StDone;
            StDone:  if (start) state_d = StGen;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StGen) || (state_q == StDrain);
        done = (state_q == StDone);
        pass = done && (err_q == 16'd0);
    end

    // The LFSRs do not step past the last pair so the operands hold it outside GEN.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            idx_q    <= 16'd0;
            drain_q  <= 3'd0;
        end else begin
            if (load) begin
                lfsr_a_q <= SEED_A;
                lfsr_b_q <= SEED_B;
                idx_q    <= 16'd0;
            end else if (state_q == StGen && !last_pair) begin
                lfsr_a_q <= {lfsr_a_q[5:0], lfsr_a_q[6] ^ lfsr_a_q[5]};
                lfsr_b_q <= {lfsr_b_q[5:0], lfsr_b_q[6] ^ lfsr_b_q[5]};
                idx_q    <= idx_q + 16'd1;
            end
            if (state_q == StGen) begin
                drain_q <= 3'd0;
            end else if (state_q == StDrain) begin
                drain_q <= drain_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                vld_q[i]  <= 1'b0;
                exp_q[i]  <= 8'd0;
                pidx_q[i] <= 16'd0;
            end
        end else begin
            vld_q[0]  <= (state_q == StGen);
            exp_q[0]  <= sum;
            pidx_q[0] <= idx_q;
            for (int unsigned i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                exp_q[i]  <= exp_q[i-1];
                pidx_q[i] <= pidx_q[i-1];
            end
        end
    end

    // err_q only returns to zero on a new run, so err_q==0 marks the first mismatch.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            err_q   <= 16'd0;
            first_q <= 16'hFFFF;
        end else if (load) begin
            err_q   <= 16'd0;
            first_q <= 16'hFFFF;
        end else if (mismatch) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (err_q == 16'd0) first_q <= pidx_q[LAT-1];
        end
    end

    assign in_a          = lfsr_a_q;
    assign in_b          = lfsr_b_q;
    assign err_cnt       = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: three instances (nominal, latency-mismatched, single-pattern) each
// wrapped around a behavioural one-cycle adder.
module tb_adder_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_m, start_l, start_o, stuck;

    logic [6:0]  in_a_m, in_b_m, in_a_l, in_b_l, in_a_o, in_b_o;
    logic [7:0]  dut_out_m, dut_out_l, dut_out_o;
    logic [7:0]  add_m_q, add_l_q, add_o_q;
    logic        busy_m, done_m, pass_m, busy_l, done_l, pass_l, busy_o, done_o, pass_o;
    logic [15:0] err_m, first_m, err_l, first_l, err_o, first_o;

    always_ff @(posedge clk) begin
        add_m_q <= {1'b0, in_a_m} + {1'b0, in_b_m};
        add_l_q <= {1'b0, in_a_l} + {1'b0, in_b_l};
        add_o_q <= {1'b0, in_a_o} + {1'b0, in_b_o};
    end
    assign dut_out_m = stuck ? {add_m_q[7:1], 1'b0} : add_m_q;
    assign dut_out_l = add_l_q;
    assign dut_out_o = add_o_q;

    adder_bist #(.LAT(1), .N_PAT(256)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start_m), .in_a(in_a_m), .in_b(in_b_m),
        .dut_out(dut_out_m), .busy(busy_m), .done(done_m), .pass(pass_m),
        .err_cnt(err_m), .first_err_idx(first_m)
    );

    adder_bist #(.LAT(2), .N_PAT(256)) u_lat (
        .clk(clk), .rst_n(rst_n), .start(start_l), .in_a(in_a_l), .in_b(in_b_l),
        .dut_out(dut_out_l), .busy(busy_l), .done(done_l), .pass(pass_l),
        .err_cnt(err_l), .first_err_idx(first_l)
    );

    adder_bist #(.LAT(3), .N_PAT(1)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start_o), .in_a(in_a_o), .in_b(in_b_o),
        .dut_out(dut_out_o), .busy(busy_o), .done(done_o), .pass(pass_o),
        .err_cnt(err_o), .first_err_idx(first_o)
    );

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
    } pair_t;

    pair_t vecs [8];
    pair_t sb [$];
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] step(input logic [6:0] x);
        return {x[5:0], x[6] ^ x[5]};
    endfunction

    // One 256-pair run on u_main; the bench LFSR model fills the scoreboard up front.
    task automatic run_main(input bit flt, input bit pulse, input bit fresh_chk);
        logic [6:0] a, b;
        logic [7:0] s;
        int         odd, first, busy_n;
        pair_t      p;
        a = 7'h01; b = 7'h7F; odd = 0; first = 16'hFFFF; busy_n = 0;
        sb.delete();
        for (int i = 0; i < 256; i++) begin
            p.a = a; p.b = b;
            sb.push_back(p);
            s = {1'b0, a} + {1'b0, b};
            if (s[0]) begin
                odd++;
                if (first == 16'hFFFF) first = i;
            end
            a = step(a); b = step(b);
        end
        stuck = flt;
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        check("busy_on_gen", 32'(busy_m), 32'd1);
        if (fresh_chk) begin
            check("restart_err_clr", 32'(err_m), 32'd0);
            check("restart_first_clr", 32'(first_m), 32'hFFFF);
        end
        for (int c = 0; c < 1000 && !done_m; c++) begin
            if (busy_m) begin
                busy_n++;
                if (sb.size() != 0) begin
                    p = sb.pop_front();
                    check("in_a", 32'(in_a_m), 32'(p.a));
                    check("in_b", 32'(in_b_m), 32'(p.b));
                    if (c < 8) begin
                        check("tab_a", 32'(in_a_m), 32'(vecs[c].a));
                        check("tab_b", 32'(in_b_m), 32'(vecs[c].b));
                    end
                end
            end
            start_m = pulse && (c == 50 || c == 256);
            @(negedge clk);
        end
        start_m = 1'b0;
        check("done", 32'(done_m), 32'd1);
        check("busy_len", 32'(busy_n), 32'd257);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("err_cnt", 32'(err_m), flt ? 32'(odd) : 32'd0);
        check("first_err", 32'(first_m), flt ? 32'(first) : 32'hFFFF);
        check("pass", 32'(pass_m), flt ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [6:0] a, b;
        logic [7:0] s0, s1;
        int         busy_n, exp_first;

        vecs[0] = '{7'h01, 7'h7F}; vecs[1] = '{7'h02, 7'h7E};
        vecs[2] = '{7'h04, 7'h7C}; vecs[3] = '{7'h08, 7'h78};
        vecs[4] = '{7'h10, 7'h70}; vecs[5] = '{7'h20, 7'h60};
        vecs[6] = '{7'h41, 7'h40}; vecs[7] = '{7'h03, 7'h01};

        rst_n = 1'b1; stuck = 1'b0;
        start_m = 1'b1; start_l = 1'b1; start_o = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", 32'({busy_m, busy_l, busy_o}), 32'd0);
        end
        check("rst_done", 32'(done_m), 32'd0);
        check("rst_pass", 32'(pass_m), 32'd0);
        check("rst_err", 32'(err_m), 32'd0);
        check("rst_first", 32'(first_m), 32'hFFFF);
        check("rst_in_a", 32'(in_a_m), 32'h01);
        check("rst_in_b", 32'(in_b_m), 32'h7F);

        rst_n = 1'b0; start_m = 1'b0; start_l = 1'b0; start_o = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy_m), 32'd0);
        check("idle_done", 32'(done_m), 32'd0);

        // Stuck-at-0 on bit 0 first, then a restart from DONE must clear the error state.
        run_main(1'b1, 1'b0, 1'b0);
        run_main(1'b0, 1'b1, 1'b1);

        // LAT=2 against a one-cycle adder compares sum(i) with sum(i+1).
        a = 7'h01; b = 7'h7F; exp_first = 16'hFFFF;
        for (int i = 0; i < 255; i++) begin
            s0 = {1'b0, a} + {1'b0, b};
            s1 = {1'b0, step(a)} + {1'b0, step(b)};
            if (s0 != s1 && exp_first == 16'hFFFF) exp_first = i;
            a = step(a); b = step(b);
        end
        busy_n = 0;
        @(negedge clk) start_l = 1'b1;
        @(negedge clk) start_l = 1'b0;
        for (int c = 0; c < 1000 && !done_l; c++) begin
            if (busy_l) busy_n++;
            @(negedge clk);
        end
        check("lat_done", 32'(done_l), 32'd1);
        check("lat_busy_len", 32'(busy_n), 32'd258);
        check("lat_err_nz", 32'(err_l != 16'd0), 32'd1);
        check("lat_first", 32'(first_l), 32'(exp_first));
        check("lat_pass", 32'(pass_l), 32'd0);

        busy_n = 0;
        @(negedge clk) start_o = 1'b1;
        @(negedge clk) start_o = 1'b0;
        check("one_in_a", 32'(in_a_o), 32'h01);
        check("one_in_b", 32'(in_b_o), 32'h7F);
        for (int c = 0; c < 100 && !done_o; c++) begin
            if (busy_o) busy_n++;
            @(negedge clk);
        end
        check("one_busy_len", 32'(busy_n), 32'd4);
        check("one_done", 32'(done_o), 32'd1);
        check("one_pass", 32'(pass_o), 32'd1);
        check("one_err", 32'(err_o), 32'd0);

        // Abort a faulty run at pattern 100 with reset.
        stuck = 1'b1;
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        for (int c = 0; c < 100; c++) @(negedge clk);
        check("mid_err_seen", 32'(err_m != 16'd0), 32'd1);
        rst_n = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy_m), 32'd0);
        check("mid_rst_done", 32'(done_m), 32'd0);
        check("mid_rst_err", 32'(err_m), 32'd0);
        check("mid_rst_first", 32'(first_m), 32'hFFFF);
        check("mid_rst_in", 32'({in_a_m, in_b_m}), 32'({7'h01, 7'h7F}));
        repeat (2) @(negedge clk);
        rst_n = 1'b0; stuck = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(busy_m), 32'd0);
        check("post_rst_err", 32'(err_m), 32'd0);
        run_main(1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
# adder_bist

Built-in self-test engine for the 7-bit ADDER. It drives pseudo-random operand pairs onto the adder inputs and receives the 8-bit sum back. It compares each sum against an internally computed golden value delayed by the adder latency, then reports a pass/fail summary. It occupies the stimulus/response position around ADDER that the PATTERN module fills in simulation, and it is synthesizable so the same check can run on silicon.

## Interface
Parameters:
- LAT, 1: adder input-to-output latency in clk cycles; legal range 1..4.
- N_PAT, 256: operand pairs issued per run; legal range 1..65535.
- SEED_A, 7'h01: operand-A LFSR seed; must be nonzero.
- SEED_B, 7'h7F: operand-B LFSR seed; must be nonzero.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- in_a  out  7  operand A to ADDER.
- in_b  out  7  operand B to ADDER.
- dut_out  in  8  sum returned by ADDER.
- busy  out  1  high in GEN and DRAIN.
- done  out  1  high while in DONE.
- pass  out  1  valid when done=1; high iff err_cnt==0.
- err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_idx  out  16  pattern index of the first mismatch; 16'hFFFF if none.

## Operation
- The FSM has four states: IDLE, GEN, DRAIN and DONE.
- IDLE --start--> GEN.
  - On entry: LFSRs load their seeds, the pattern index clears to 0, err_cnt clears to 0, and first_err_idx is set to 16'hFFFF.
- GEN issues one pair per cycle, with index 0..N_PAT-1.
  - After index N_PAT-1 is issued, go to DRAIN.
- DRAIN lasts exactly LAT cycles, then goes to DONE.
- DONE --start--> GEN, with the same re-initialisation as from IDLE. Results hold until then.
- start is ignored in GEN and DRAIN.
- LFSR step, applied per issued pair:
  - x = {x[5:0], x[6]^x[5]}, period 127.
  - Both LFSRs advance every GEN cycle.
  - in_a/in_b equal the current LFSR values during GEN.
  - in_a/in_b hold their last values outside GEN.
- Golden value is exp = {1'b0,in_a} + {1'b0,in_b}, an 8-bit unsigned sum with no truncation; the maximum is 8'hFE.
- exp, a valid bit and the 16-bit index travel through a LAT-stage shift register aligned with ADDER.
  - When the stage-LAT valid bit is 1, compare dut_out to the delayed exp.
  - On a mismatch, err_cnt increments (saturating).
  - On the first mismatch only, first_err_idx takes the delayed index.
- pass = done & (err_cnt==0).

## Timing
- Reset values: busy=0, done=0, pass=0, err_cnt=0, first_err_idx=16'hFFFF, in_a=SEED_A, in_b=SEED_B, FSM=IDLE, all pipeline valid bits=0.
- Reset is asynchronous and applies in any state. A run aborted mid-operation leaves no residue: pipeline valids clear and a fresh start is required.
- Run timing:
  - start sampled at edge k gives GEN from cycle k+1.
  - Pair i is on in_a/in_b during cycle k+1+i.
  - Its result is compared at edge k+1+i+LAT.
  - busy is high for N_PAT+LAT cycles.
  - done rises in cycle k+1+N_PAT+LAT.
- The last comparison occurs on the final DRAIN edge, so err_cnt is final when done rises.
- A start in the same cycle DONE is entered is not seen; it must arrive while done=1.
- Index wrap: N_PAT ≤ 65535, so the index never wraps. LFSR sequences repeat every 127 pairs by design.

## Test plan
- Reset: assert rst_n for 3 cycles with start=1 → all outputs at reset values, busy never asserts; after release with start=0, stays IDLE.
- Golden run: behavioural ADDER model with LAT=1, N_PAT=256, start at cycle 10 → first pair in_a=7'h01, in_b=7'h7F with dut_out=8'h80 one cycle later; busy for 257 cycles; done=1, pass=1, err_cnt=0, first_err_idx=16'hFFFF.
- Fault injection: force dut_out[0] stuck-at-0 → err_cnt equals the number of odd expected sums; first_err_idx is the first index with an odd sum; pass=0.
- Latency mismatch: BIST LAT=2 against a 1-cycle adder → err_cnt>0, pass=0. Rerun with LAT=1 → pass=1.
- Control corners: start pulses during GEN and DRAIN are ignored, with no index reset. start in DONE restarts with err_cnt cleared and first_err_idx=16'hFFFF. With N_PAT=1, busy lasts LAT+1 cycles.
- Reset mid-run: assert rst_n at pattern 100 → immediate return to reset values, no further compares; a following start gives a clean pass.
